fetch_queue: RTL and testbench

Instruction fetch front end that consumes the program counter and produces the halt that throttles it. Each cycle it issues the current PC to instruction memory when a queue slot is free, holds `halt_po` high otherwise, and returns fetched instructions in order to decode through a valid/ready buffer. A taken-branch flush discards queued entries and drops in-flight responses, so the PC can redirect without stale instructions leaking downstream.

---
 rtl/fetch_queue.sv | 111 +++++++++++
 tb/tb_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PCs to instruction memory, tracks in-order responses,
// and presents fetched instructions to decode; flush drops queued and in-flight work.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_pi,
    input  logic        reset_n_pi,
    input  logic [31:0] pc_pi,
    input  logic        flush_pi,
    output logic        halt_po,
    output logic        imem_req_po,
    output logic [31:0] imem_addr_po,
    input  logic        imem_rdy_pi,
    input  logic        imem_rvalid_pi,
    input  logic [31:0] imem_rdata_pi,
    output logic        inst_valid_po,
    output logic [31:0] inst_po,
    output logic [31:0] inst_pc_po,
    input  logic        inst_ready_pi
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    alloc_ptr_q;
    logic [PW-1:0]    fill_ptr_q;
    logic [PW-1:0]    head_ptr_q;
    logic [CW-1:0]    alloc_cnt_q;
    logic [CW-1:0]    drop_cnt_q;
    logic [CW-1:0]    inflight_q;

    logic        accept;
    logic        fill;
    logic        drop_resp;
    logic        pop;
    logic [CW:0] occupancy;

    // Dropped responses still hold a memory slot's worth of credit until they return.
    assign occupancy     = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_po   = reset_n_pi & ~flush_pi & (occupancy < DEPTH_W);
    assign imem_addr_po  = pc_pi;
    assign accept        = imem_req_po & imem_rdy_pi;
    assign halt_po       = ~accept;

    assign drop_resp     = imem_rvalid_pi & ~flush_pi & (drop_cnt_q != '0);
    assign fill          = imem_rvalid_pi & ~flush_pi & (drop_cnt_q == '0);

    assign inst_valid_po = alloc_q[head_ptr_q] & filled_q[head_ptr_q];
    assign inst_po       = inst_valid_po ? data_q[head_ptr_q] : '0;
    assign inst_pc_po    = inst_valid_po ? pc_q[head_ptr_q] : '0;
    assign pop           = inst_valid_po & inst_ready_pi & ~flush_pi;

    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            alloc_q     <= '0;
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            drop_cnt_q  <= '0;
            inflight_q  <= '0;
        end else if (flush_pi) begin
            alloc_q     <= '0;
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            inflight_q  <= '0;
            // A response landing in the flush cycle settles one of the in-flight requests.
            drop_cnt_q  <= drop_cnt_q + inflight_q - CW'(imem_rvalid_pi);
        end else begin
            if (accept) begin
                alloc_q[alloc_ptr_q]  <= 1'b1;
                filled_q[alloc_ptr_q] <= 1'b0;
                alloc_ptr_q           <= alloc_ptr_q + PW'(1);
            end
            if (fill) begin
                filled_q[fill_ptr_q] <= 1'b1;
                fill_ptr_q           <= fill_ptr_q + PW'(1);
            end
            if (pop) begin
                alloc_q[head_ptr_q]  <= 1'b0;
                filled_q[head_ptr_q] <= 1'b0;
                head_ptr_q           <= head_ptr_q + PW'(1);
            end
            if (drop_resp) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CW'(accept) - CW'(pop);
            inflight_q  <= inflight_q + CW'(accept) - CW'(fill);
        end
    end

    // Payload storage needs no reset; validity bits gate every read.
    always_ff @(posedge clk_pi) begin
        if (accept) begin
            pc_q[alloc_ptr_q] <= pc_pi;
        end
        if (fill) begin
            data_q[fill_ptr_q] <= imem_rdata_pi;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model, PC register and fixed-latency memory,
// with per-cycle output comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;

    int total = 0;
    int bad = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_pi        (clk),
        .reset_n_pi    (reset_n),
        .pc_pi         (pc),
        .flush_pi      (flush),
        .halt_po       (halt),
        .imem_req_po   (imem_req),
        .imem_addr_po  (imem_addr),
        .imem_rdy_pi   (imem_rdy),
        .imem_rvalid_pi(imem_rvalid),
        .imem_rdata_pi (imem_rdata),
        .inst_valid_po (inst_valid),
        .inst_po       (inst),
        .inst_pc_po    (inst_pc),
        .inst_ready_pi (inst_ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ent_t        fifo[$];
    mreq_t       pend[$];
    int          drop = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] target = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, PC register and memory all advance on the clock edge.
    bit    m_req, m_valid, m_acc;
    int    unf;
    ent_t  ent;
    mreq_t rq;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo.delete();
            pend.delete();
            drop        = 0;
            pc_reg      = 32'h0;
            cyc         = 0;
            pc          = 32'h0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            m_req   = !flush && (fifo.size() + drop < DEPTH);
            m_valid = (fifo.size() > 0) && fifo[0].filled;
            m_acc   = m_req && imem_rdy;
            if (flush) begin
                unf = 0;
                foreach (fifo[i]) if (!fifo[i].filled) unf++;
                drop = drop + unf - int'(imem_rvalid);
                fifo.delete();
            end else begin
                if (imem_rvalid) begin
                    if (drop > 0) begin
                        drop--;
                    end else begin
                        for (int i = 0; i < fifo.size(); i++) begin
                            if (!fifo[i].filled) begin
                                ent = fifo[i];
                                ent.filled = 1'b1;
                                ent.data = imem_rdata;
                                fifo[i] = ent;
                                break;
                            end
                        end
                    end
                end
                if (m_valid && inst_ready) void'(fifo.pop_front());
                if (m_acc) begin
                    ent.pc = pc;
                    ent.data = 32'h0;
                    ent.filled = 1'b0;
                    fifo.push_back(ent);
                end
            end
            if (m_acc) begin
                rq.addr = pc;
                rq.due = cyc + lat;
                pend.push_back(rq);
            end
            if (flush) pc_reg = target;
            else if (m_acc) pc_reg = pc_reg + 32'd4;
            cyc++;
            #1;
            pc = pc_reg;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    bit e_req, e_valid;
    always @(negedge clk) begin
        e_req   = reset_n && !flush && (fifo.size() + drop < DEPTH);
        e_valid = reset_n && (fifo.size() > 0) && fifo[0].filled;
        chk("halt", halt, !(e_req && imem_rdy));
        chk("imem_req", imem_req, e_req);
        chk("imem_addr", imem_addr, pc);
        chk("inst_valid", inst_valid, e_valid);
        chk("inst", inst, e_valid ? fifo[0].data : 32'h0);
        chk("inst_pc", inst_pc, e_valid ? fifo[0].pc : 32'h0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Reset asserted between edges, released just after a rising edge (cycle C0 follows).
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        mid();
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_halt", halt, 1);
        chk("rst_req", imem_req, 0);

        // Streaming with 1-cycle memory.
        lat = 1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            mid();
            chk("stream_halt", halt, 0);
            if (k >= 2) begin
                chk("stream_valid", inst_valid, 1);
                chk("stream_pc", inst_pc, 32'(4 * (k - 2)));
                chk("stream_data", inst, mem_word(32'(4 * (k - 2))));
            end
            next_cycle();
        end

        // Back-pressure fills all slots.
        inst_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("bp_accept_halt", halt, 0);
            chk("bp_accept_addr", imem_addr, 32'(4 * k));
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("bp_full_halt", halt, 1);
            chk("bp_hold_addr", imem_addr, 32'd16);
            next_cycle();
        end
        inst_ready = 1'b1;
        mid();
        chk("bp_pop_halt", halt, 1);
        chk("bp_pop_head", inst_pc, 32'd0);
        next_cycle();
        mid();
        chk("bp_resume_halt", halt, 0);
        chk("bp_resume_addr", imem_addr, 32'd16);
        chk("bp_next_head", inst_pc, 32'd4);
        next_cycle();

        // Memory stall.
        do_reset();
        for (int k = 0; k < 3; k++) next_cycle();
        imem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("stall_halt", halt, 1);
            chk("stall_addr", imem_addr, 32'd12);
            next_cycle();
        end
        imem_rdy = 1'b1;
        mid();
        chk("stall_release_halt", halt, 0);
        chk("stall_release_addr", imem_addr, 32'd12);
        next_cycle();

        // Flush with responses in flight, 3-cycle memory.
        lat = 3;
        do_reset();
        for (int k = 0; k < 4; k++) next_cycle();
        flush = 1'b1;
        target = 32'h100;
        mid();
        chk("fl_head_before", inst_pc, 32'd0);
        next_cycle();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("fl_no_stale", inst_valid, 0);
            next_cycle();
        end
        mid();
        chk("fl_first_valid", inst_valid, 1);
        chk("fl_first_pc", inst_pc, 32'h100);
        chk("fl_first_data", inst, mem_word(32'h100));
        next_cycle();

        // Flush coincident with the only outstanding response.
        lat = 1;
        do_reset();
        next_cycle();
        flush = 1'b1;
        target = 32'h200;
        mid();
        chk("flr_halt", halt, 1);
        next_cycle();
        flush = 1'b0;
        mid();
        chk("flr_req_halt", halt, 0);
        chk("flr_req_addr", imem_addr, 32'h200);
        chk("flr_no_stale0", inst_valid, 0);
        next_cycle();
        mid();
        chk("flr_no_stale1", inst_valid, 0);
        next_cycle();
        mid();
        chk("flr_valid", inst_valid, 1);
        chk("flr_pc", inst_pc, 32'h200);
        chk("flr_data", inst, mem_word(32'h200));
        next_cycle();

        // Asynchronous reset mid-stream.
        mid();
        chk("ar_valid_before", inst_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", inst_valid, 0);
        chk("ar_inst", inst, 0);
        chk("ar_inst_pc", inst_pc, 0);
        chk("ar_halt", halt, 1);
        chk("ar_req", imem_req, 0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
